// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and the
// slice-width helper used by pipe_adder.
package pipe_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Width of one pipeline slice.
    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple adder with carry in/out, built from fulladder
// cells. Each bit keeps its own carry net so the ripple is not one vector
// feeding back on itself.
module adder_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_ci,
    output logic [SW-1:0] o_sum,
    output logic          o_co
);

    for (genvar i = 0; i < SW; i++) begin : g_bit
        logic w_cin;
        logic w_cout;

        if (i == 0) begin : g_lsb
            assign w_cin = i_ci;
        end else begin : g_up
            assign w_cin = g_bit[i-1].w_cout;
        end

        fulladder u_fa (
            .i_a  (i_a[i]),
            .i_b  (i_b[i]),
            .i_ci (w_cin),
            .o_s  (o_sum[i]),
            .o_co (w_cout)
        );
    end

    assign o_co = g_bit[SW-1].w_cout;

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell; the building block of every adder slice.
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined carry-chain adder: a WIDTH-bit add with carry-in split into
// STAGES registered slices, valid/ready at both ends with a global stall.
// Optional macro PIPE_ADDER_OVF_EN adds out_ovf (signed overflow flag).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int unsigned SW   = slice_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_illegal
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    // Per-stage state: valid, slice carry, summed low bits, and the operands
    // travelling alongside so later stages find their unsummed upper slices.
    logic             r_v   [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];

    logic [SW-1:0]    w_ps  [STAGES];
    logic             w_co  [STAGES];
    logic             w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [SW-1:0] w_sa;
        logic [SW-1:0] w_sb;
        logic          w_ci;

        if (k == 0) begin : g_first
            assign w_sa = in_a[SW-1:0];
            assign w_sb = in_b[SW-1:0];
            assign w_ci = in_ci;
        end else begin : g_next
            assign w_sa = r_a[k-1][k*SW +: SW];
            assign w_sb = r_b[k-1][k*SW +: SW];
            assign w_ci = r_c[k-1];
        end

        adder_slice #(.SW(SW)) u_slice (
            .i_a   (w_sa),
            .i_b   (w_sb),
            .i_ci  (w_ci),
            .o_sum (w_ps[k]),
            .o_co  (w_co[k])
        );
    end

    // Whole pipe advances together unless the output is held.
    assign w_adv    = !r_v[LAST] | out_ready;
    assign in_ready = w_adv;

    // Stage registers; data only loads behind a valid token so bubbles never
    // disturb the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            if (in_valid) begin
                r_a[0]           <= in_a;
                r_b[0]           <= in_b;
                r_c[0]           <= w_co[0];
                r_sum[0]         <= '0;
                r_sum[0][SW-1:0] <= w_ps[0];
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) begin
                    r_a[k]               <= r_a[k-1];
                    r_b[k]               <= r_b[k-1];
                    r_c[k]               <= w_co[k];
                    r_sum[k]             <= r_sum[k-1];
                    r_sum[k][k*SW +: SW] <= w_ps[k];
                end
            end
        end
    end

    assign out_valid = r_v[LAST];
    assign out_sum   = r_sum[LAST];
    assign out_co    = r_c[LAST];

`ifdef PIPE_ADDER_OVF_EN
    // Derived only from final-stage registers, so it resets and holds with out_sum.
    assign out_ovf = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1]) &
                     (r_sum[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, STAGES=4).
module tb_pipe_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ovf;
        int unsigned acc;
        bit          lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_co;
`ifdef PIPE_ADDER_OVF_EN
    logic             out_ovf;
`endif

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    exp_t        q[$];
    bit          lat_on   = 1'b0;
    bit          rnd_rdy  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    bit          head_seen = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_idle  = 1'b0;
    logic [15:0] prev_sum;
    logic        prev_co;
    always @(negedge clk) begin
        if (!rst_n) begin
            head_seen  = 1'b0;
            prev_stall = 1'b0;
            prev_idle  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_hold_sum", {16'b0, out_sum}, {16'b0, prev_sum});
                chk("stall_hold_co", {31'b0, out_co}, {31'b0, prev_co});
            end
            if (prev_idle && !out_valid)
                chk("bubble_hold_sum", {16'b0, out_sum}, {16'b0, prev_sum});
            if (out_valid) begin
                if (!out_ready) chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_result: got sum %h with no result expected", out_sum);
                end else begin
                    if (!head_seen && q[0].lat) chk("latency", cyc - q[0].acc, STAGES);
                    head_seen = 1'b1;
                    chk("sum", {16'b0, out_sum}, {16'b0, q[0].s});
                    chk("co", {31'b0, out_co}, {31'b0, q[0].co});
`ifdef PIPE_ADDER_OVF_EN
                    chk("ovf", {31'b0, out_ovf}, {31'b0, q[0].ovf});
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_idle  = !out_valid;
            prev_sum   = out_sum;
            prev_co    = out_co;
        end
    end

    // Random consumer backpressure, active only in the random phase.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input vec_t v);
        int unsigned t = 0;
        exp_t e;
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_ci    = v.ci;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end else begin
            e.s   = v.s;
            e.co  = v.co;
            e.ovf = v.ovf;
            e.acc = cyc;
            e.lat = lat_on;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // a, b, ci, expected sum, co, ovf (hand computed)
    vec_t dir_v[8] = '{
        '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0},
        '{16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0},
        '{16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1, 1'b0}
    };

    vec_t bp_v[6] = '{
        '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0},
        '{16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7000, 16'h1000, 1'b1, 16'h8001, 1'b0, 1'b1},
        '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0},
        '{16'h8001, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0}
    };

    vec_t rst_v[4] = '{
        '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0},
        '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0},
        '{16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0, 1'b0}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [16:0] full;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'b0, out_sum}, 32'd0);
        chk("rst_out_co", {31'b0, out_co}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back directed vectors, latency checked on each result.
        lat_on = 1'b1;
        foreach (dir_v[i]) send(dir_v[i]);
        idle();
        drain();
        lat_on = 1'b0;

        // Six back-to-back ops with the consumer stalled for four cycles.
        fork
            begin
                foreach (bp_v[i]) send(bp_v[i]);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Fill the pipe with the consumer stalled, then reset mid-stream.
        out_ready = 1'b0;
        foreach (rst_v[i]) send(rst_v[i]);
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_sum", {16'b0, out_sum}, 32'd0);
        chk("async_rst_co", {31'b0, out_co}, 32'd0);
        q.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        lat_on = 1'b1;
        v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        send(v);
        idle();
        drain();
        lat_on = 1'b0;

        // Random operands, random gaps and random consumer backpressure.
        rnd_rdy = 1'b1;
        for (int unsigned n = 0; n < 300; n++) begin
            v.a  = 16'($urandom);
            v.b  = 16'($urandom);
            v.ci = 1'($urandom_range(0, 1));
            full = {1'b0, v.a} + {1'b0, v.b} + {16'b0, v.ci};
            v.s  = full[15:0];
            v.co = full[16];
            v.ovf = (v.a[15] == v.b[15]) && (full[15] != v.a[15]);
            send(v);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        idle();
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
